// File: rtl/eth_tx_arb_pkg.sv
// eth_tx_arb_pkg
//   Shared definitions for the Ethernet TX frame arbiter:
//   - arb_state_e : arbiter FSM states
//   - CNT_W       : width of the optional per-port statistics counters
//   - grant_idx_w : width of a port index for a given port count
package eth_tx_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_PASS       = 2'd1,
      ST_ABORT_EMIT = 2'd2,
      ST_DRAIN      = 2'd3
   } arb_state_e;

   localparam int CNT_W = 16;

   // A single-port build still needs a one-bit index.
   function automatic int grant_idx_w(input int ports);
      return (ports > 1) ? $clog2(ports) : 1;
   endfunction

endpackage

// File: rtl/eth_rr_select.sv
// eth_rr_select
//   Purely combinational round-robin priority selector. Searches req starting
//   at last+1 (wrapping modulo PORTS) and returns the first requester found;
//   the port named by last is therefore checked last.
// Ports:
//   req   [PORTS-1:0] : request vector
//   last  [IDX_W-1:0] : previously served port
//   grant [IDX_W-1:0] : selected port (0 when nothing is found)
//   found             : at least one request was present
module eth_rr_select
   import eth_tx_arb_pkg::*;
#(
   parameter int PORTS = 4,
   parameter int IDX_W = grant_idx_w(PORTS)
) (
   input  logic [PORTS-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic [IDX_W-1:0] grant,
   output logic             found
);

   always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      found = 1'b0;
      for (int i = 1; i <= PORTS; i++) begin
         idx = (int'(last) + i) % PORTS;
         if (!found && req[idx]) begin
            grant = IDX_W'(idx);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eth_tx_frame_arb.sv
// eth_tx_frame_arb
//   Frame-level round-robin arbiter merging PORTS byte-wide AXI-stream sources
//   into one stream toward the MAC TX FIFO. A grant is held for a whole frame.
//   A source that goes silent mid-frame for STALL_TIMEOUT cycles is cut off:
//   a single 0x00 beat with tlast=1/tuser=1 terminates the frame downstream and
//   the rest of the source frame is drained and discarded.
// Ports:
//   tx_clk, tx_rst           : clock, asynchronous active-high reset
//   s_axis_* (per port)      : source streams, byte of port i at tdata[8i+7:8i]
//   m_axis_*                 : merged stream toward the MAC TX FIFO
//   grant_valid, grant_idx   : current frame owner
//   abort_pulse              : one-cycle pulse per watchdog abort
//   frame_cnt, abort_cnt     : saturating per-port statistics, 16 bits per port
//                              (present only with ETH_TX_ARB_STATS_EN defined)
// Configuration macro: ETH_TX_ARB_STATS_EN
module eth_tx_frame_arb
   import eth_tx_arb_pkg::*;
#(
   parameter int PORTS         = 4,
   parameter int STALL_TIMEOUT = 256
) (
   input  logic                            tx_clk,
   input  logic                            tx_rst,
   input  logic [PORTS*8-1:0]              s_axis_tdata,
   input  logic [PORTS-1:0]                s_axis_tvalid,
   input  logic [PORTS-1:0]                s_axis_tlast,
   input  logic [PORTS-1:0]                s_axis_tuser,
   output logic [PORTS-1:0]                s_axis_tready,
   output logic [7:0]                      m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   output logic                            m_axis_tuser,
   output logic                            grant_valid,
   output logic [grant_idx_w(PORTS)-1:0]   grant_idx,
   output logic                            abort_pulse
`ifdef ETH_TX_ARB_STATS_EN
   ,
   output logic [PORTS*CNT_W-1:0]          frame_cnt,
   output logic [PORTS*CNT_W-1:0]          abort_cnt
`endif
);

   localparam int IDX_W   = grant_idx_w(PORTS);
   // The counter only has to reach STALL_TIMEOUT-1; the next idle cycle aborts.
   localparam int STALL_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   last_grant_q, last_grant_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               abort_q, abort_d;

   logic [IDX_W-1:0]   rr_grant;
   logic               rr_found;

   logic [7:0]         s_byte [PORTS];
   logic [7:0]         sel_data;
   logic               sel_valid, sel_last, sel_user;

   for (genvar gi = 0; gi < PORTS; gi++) begin : g_byte
      assign s_byte[gi] = s_axis_tdata[8*gi +: 8];
   end

   assign sel_data  = s_byte[grant_q];
   assign sel_valid = s_axis_tvalid[grant_q];
   assign sel_last  = s_axis_tlast[grant_q];
   assign sel_user  = s_axis_tuser[grant_q];

   eth_rr_select #(
      .PORTS (PORTS),
      .IDX_W (IDX_W)
   ) u_rr (
      .req   (s_axis_tvalid),
      .last  (last_grant_q),
      .grant (rr_grant),
      .found (rr_found)
   );

   always_ff @(posedge tx_clk or posedge tx_rst) begin
      if (tx_rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(PORTS - 1);
         stall_q      <= '0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         stall_q      <= stall_d;
         abort_q      <= abort_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      stall_d       = '0;
      abort_d       = 1'b0;
      s_axis_tready = '0;
      m_axis_tdata  = 8'h00;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rr_found) begin
               grant_d = rr_grant;
               state_d = ST_PASS;
            end
         end

         ST_PASS: begin
            m_axis_tdata           = sel_data;
            m_axis_tvalid          = sel_valid;
            m_axis_tlast           = sel_last;
            m_axis_tuser           = sel_user;
            s_axis_tready[grant_q] = m_axis_tready;
            if (sel_valid && m_axis_tready) begin
               if (sel_last) begin
                  // Recording the owner here puts it last in the next search,
                  // so a back-to-back request from it cannot jump the queue.
                  last_grant_d = grant_q;
                  state_d      = ST_IDLE;
               end
            end else if (!sel_valid) begin
               if (STALL_TIMEOUT != 0) begin
                  if (stall_q == STALL_W'(STALL_TIMEOUT - 1)) begin
                     state_d = ST_ABORT_EMIT;
                     abort_d = 1'b1;
                  end else begin
                     stall_d = stall_q + 1'b1;
                  end
               end
            end else begin
               // Downstream backpressure: hold the count, do not advance it.
               stall_d = stall_q;
            end
         end

         ST_ABORT_EMIT: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
            m_axis_tuser  = 1'b1;
            if (m_axis_tready) begin
               state_d = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            s_axis_tready[grant_q] = 1'b1;
            if (sel_valid && sel_last) begin
               last_grant_d = grant_q;
               state_d      = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign grant_valid = (state_q != ST_IDLE);
   assign grant_idx   = grant_q;
   assign abort_pulse = abort_q;

`ifdef ETH_TX_ARB_STATS_EN
   logic frame_done;
   assign frame_done = (state_q == ST_PASS) && sel_valid && m_axis_tready && sel_last;

   for (genvar gi = 0; gi < PORTS; gi++) begin : g_stats
      logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
      logic [CNT_W-1:0] abort_cnt_q, abort_cnt_d;
      logic             owner;

      assign owner = (grant_q == IDX_W'(gi));

      // abort_q is high in the first ABORT_EMIT cycle, while grant_q still
      // names the offending port.
      always_comb begin
         frame_cnt_d = frame_cnt_q;
         abort_cnt_d = abort_cnt_q;
         if (frame_done && owner && (frame_cnt_q != '1)) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
         if (abort_q && owner && (abort_cnt_q != '1)) begin
            abort_cnt_d = abort_cnt_q + 1'b1;
         end
      end

      always_ff @(posedge tx_clk or posedge tx_rst) begin
         if (tx_rst) begin
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
         end else begin
            frame_cnt_q <= frame_cnt_d;
            abort_cnt_q <= abort_cnt_d;
         end
      end

      assign frame_cnt[gi*CNT_W +: CNT_W] = frame_cnt_q;
      assign abort_cnt[gi*CNT_W +: CNT_W] = abort_cnt_q;
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// tb_eth_tx_frame_arb
//   Directed bench for eth_tx_frame_arb (PORTS=4, STALL_TIMEOUT=16).
//   Per-port beat tables feed a single driver process; expected output beats
//   are queued when each scenario is issued and a separate monitor pops and
//   compares them as the arbiter presents accepted beats.
//   Build with ETH_TX_ARB_STATS_EN to also check the statistics counters.
module tb_eth_tx_frame_arb;

   localparam int PORTS = 4;
   localparam int TMO   = 16;
   localparam int DEPTH = 512;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [PORTS*8-1:0] s_tdata;
   logic [PORTS-1:0]   s_tvalid, s_tlast, s_tuser, s_tready;
   logic [7:0]         m_tdata;
   logic               m_tvalid, m_tready, m_tlast, m_tuser;
   logic               grant_valid, abort_pulse;
   logic [1:0]         grant_idx;
`ifdef ETH_TX_ARB_STATS_EN
   logic [PORTS*16-1:0] frame_cnt, abort_cnt;
`endif

   always #5 clk = ~clk;

   eth_tx_frame_arb #(
      .PORTS         (PORTS),
      .STALL_TIMEOUT (TMO)
   ) dut (
      .tx_clk        (clk),
      .tx_rst        (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tuser  (s_tuser),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .m_axis_tuser  (m_tuser),
      .grant_valid   (grant_valid),
      .grant_idx     (grant_idx),
      .abort_pulse   (abort_pulse)
`ifdef ETH_TX_ARB_STATS_EN
      ,
      .frame_cnt     (frame_cnt),
      .abort_cnt     (abort_cnt)
`endif
   );

   typedef struct packed {
      logic [7:0]  data;
      logic        last;
      logic        user;
      logic [15:0] gap;   // idle cycles before this beat is presented
   } beat_t;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       user;
      logic [1:0] idx;
   } exp_t;

   beat_t mem [PORTS][DEPTH];
   int    wr_ptr   [PORTS];
   int    rd_ptr   [PORTS];
   int    gap_left [PORTS];
   bit    loaded   [PORTS];
   bit    will_acc [PORTS];

   exp_t  exp_q [$];
   int    total = 0;
   int    bad   = 0;
   int    cyc = 0;
   int    beats_seen = 0;
   int    tlast_seen = 0;
   int    abort_seen = 0;
   int    last_beat_cyc = 0;
   int    abort_gap = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic load_frame(input int p, input int len, input int base,
                             input int stall_idx, input int stall_gap);
      for (int i = 0; i < len; i++) begin
         mem[p][wr_ptr[p]] = {8'(base + i), (i == len - 1), 1'b0,
                              16'((i == stall_idx) ? stall_gap : 0)};
         wr_ptr[p]++;
      end
   endtask

   task automatic expect_frame(input int p, input int n, input int len, input int base);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({8'(base + i), (i == len - 1), 1'b0, 2'(p)});
      end
   endtask

   task automatic expect_abort(input int p);
      exp_q.push_back({8'h00, 1'b1, 1'b1, 2'(p)});
   endtask

   function automatic bit all_empty();
      for (int p = 0; p < PORTS; p++) begin
         if (rd_ptr[p] != wr_ptr[p]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic wait_idle(input string name);
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
         done = (exp_q.size() == 0) && !grant_valid && all_empty();
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL %s_idle actual=busy(pending=%0d) required=idle", name, exp_q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_beats(input int target);
      for (int i = 0; i < 1000 && beats_seen < target; i++) @(negedge clk);
   endtask

   // Source driver: all ports from one process. Inputs change on the falling
   // edge; the acceptance decision for the coming rising edge is taken 1 time
   // unit later, once the combinational tready has settled.
   initial begin
      s_tvalid = '0;
      s_tdata  = '0;
      s_tlast  = '0;
      s_tuser  = '0;
      for (int p = 0; p < PORTS; p++) begin
         rd_ptr[p] = 0; wr_ptr[p] = 0; gap_left[p] = 0;
         loaded[p] = 1'b0; will_acc[p] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int p = 0; p < PORTS; p++) begin
            if (rst) begin
               rd_ptr[p]   = wr_ptr[p];
               loaded[p]   = 1'b0;
               will_acc[p] = 1'b0;
            end
            if (will_acc[p]) begin
               rd_ptr[p]++;
               loaded[p] = 1'b0;
            end
            if (!loaded[p] && rd_ptr[p] != wr_ptr[p]) begin
               gap_left[p] = int'(mem[p][rd_ptr[p]].gap);
               loaded[p]   = 1'b1;
            end
            if (loaded[p] && gap_left[p] == 0) begin
               s_tvalid[p]       = 1'b1;
               s_tdata[p*8 +: 8] = mem[p][rd_ptr[p]].data;
               s_tlast[p]        = mem[p][rd_ptr[p]].last;
               s_tuser[p]        = mem[p][rd_ptr[p]].user;
            end else begin
               s_tvalid[p]       = 1'b0;
               s_tdata[p*8 +: 8] = 8'h00;
               s_tlast[p]        = 1'b0;
               s_tuser[p]        = 1'b0;
               if (loaded[p]) gap_left[p]--;
            end
         end
         #1;
         for (int p = 0; p < PORTS; p++) begin
            will_acc[p] = s_tvalid[p] && s_tready[p] && !rst;
         end
      end
   end

   // Monitor: every beat that will be accepted at the next rising edge is
   // compared against the head of the expectation queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         #2;
         if (abort_pulse) begin
            abort_seen++;
            abort_gap = cyc - last_beat_cyc;
         end
         if (m_tvalid && m_tready) begin
            beats_seen++;
            last_beat_cyc = cyc;
            if (m_tlast) tlast_seen++;
            $display("beat %0d: port=%0d data=%02h last=%0b user=%0b",
                     beats_seen, grant_idx, m_tdata, m_tlast, m_tuser);
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_beat actual=port%0d/%02h/l%0b/u%0b required=none",
                        grant_idx, m_tdata, m_tlast, m_tuser);
            end else begin
               e = exp_q.pop_front();
               if ({m_tdata, m_tlast, m_tuser, grant_idx, grant_valid} !== {e, 1'b1}) begin
                  bad++;
                  $display("FAIL beat actual=port%0d/%02h/l%0b/u%0b/gv%0b required=port%0d/%02h/l%0b/u%0b/gv1",
                           grant_idx, m_tdata, m_tlast, m_tuser, grant_valid,
                           e.idx, e.data, e.last, e.user);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      bad++;
      $display("FAIL global_timeout actual=running required=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "global timeout");
   end

   initial begin
      int b0, t0, a0;
      m_tready = 1'b1;
      rst      = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_m_tvalid",     32'(m_tvalid),    32'd0);
      chk("rst_grant_valid",  32'(grant_valid), 32'd0);
      chk("rst_s_tready",     32'(s_tready),    32'd0);
      chk("rst_abort_pulse",  32'(abort_pulse), 32'd0);
      chk("rst_grant_idx",    32'(grant_idx),   32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1) four simultaneous 64-byte frames: served 0,1,2,3 whole
      b0 = beats_seen; t0 = tlast_seen;
      for (int p = 0; p < PORTS; p++) load_frame(p, 64, p * 64, -1, 0);
      for (int p = 0; p < PORTS; p++) expect_frame(p, 64, 64, p * 64);
      wait_idle("t1");
      chk("t1_beats", 32'(beats_seen - b0), 32'd256);
      chk("t1_tlast", 32'(tlast_seen - t0), 32'd4);

      // 2) port 2 streaming back to back, port 1 requesting: alternate
      for (int f = 0; f < 3; f++) load_frame(2, 8, 8'h80 + 16 * f, -1, 0);
      for (int f = 0; f < 2; f++) load_frame(1, 8, 8'h40 + 16 * f, -1, 0);
      expect_frame(1, 8, 8, 8'h40);
      expect_frame(2, 8, 8, 8'h80);
      expect_frame(1, 8, 8, 8'h50);
      expect_frame(2, 8, 8, 8'h90);
      expect_frame(2, 8, 8, 8'hA0);
      wait_idle("t2");

      // 3) port 0 stalls after 10 of 60 bytes: abort, drain, then port 1
      a0 = abort_seen;
      load_frame(0, 60, 8'h10, 10, 30);
      load_frame(1, 4, 8'hC0, -1, 0);
      expect_frame(0, 10, 60, 8'h10);
      expect_abort(0);
      expect_frame(1, 4, 4, 8'hC0);
      wait_idle("t3");
      chk("t3_abort_count", 32'(abort_seen - a0), 32'd1);
      chk("t3_abort_delay", 32'(abort_gap), 32'(TMO + 1));

      // 4) 1000 cycles of downstream backpressure mid-frame: no abort
      a0 = abort_seen; b0 = beats_seen;
      load_frame(2, 20, 8'h30, -1, 0);
      expect_frame(2, 20, 20, 8'h30);
      wait_beats(b0 + 5);
      m_tready = 1'b0;
      repeat (1000) @(negedge clk);
      chk("t4_hold_grant", 32'(grant_valid), 32'd1);
      m_tready = 1'b1;
      wait_idle("t4");
      chk("t4_no_abort", 32'(abort_seen - a0), 32'd0);

      // 5) reset during PASS: frame abandoned, outputs low, port 0 wins next
      b0 = beats_seen;
      load_frame(3, 30, 8'h60, -1, 0);
      expect_frame(3, 5, 30, 8'h60);
      wait_beats(b0 + 5);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("t5_m_tvalid",    32'(m_tvalid),    32'd0);
      chk("t5_m_tlast",     32'(m_tlast),     32'd0);
      chk("t5_m_tdata",     32'(m_tdata),     32'd0);
      chk("t5_grant_valid", 32'(grant_valid), 32'd0);
      chk("t5_s_tready",    32'(s_tready),    32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("t5_partial_beats", 32'(beats_seen - b0), 32'd5);
      load_frame(0, 8, 8'hA0, -1, 0);
      load_frame(3, 8, 8'hB0, -1, 0);
      expect_frame(0, 8, 8, 8'hA0);
      expect_frame(3, 8, 8, 8'hB0);
      wait_idle("t5");

      // 6) fresh reset, three frames on port 1 and one abort on port 3
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      a0 = abort_seen;
      for (int f = 0; f < 3; f++) load_frame(1, 4, 8'hD0 + 4 * f, -1, 0);
      load_frame(3, 20, 8'hE0, 3, 30);
      expect_frame(1, 4, 4, 8'hD0);
      expect_frame(3, 3, 20, 8'hE0);
      expect_abort(3);
      expect_frame(1, 4, 4, 8'hD4);
      expect_frame(1, 4, 4, 8'hD8);
      wait_idle("t6");
      chk("t6_abort_count", 32'(abort_seen - a0), 32'd1);
`ifdef ETH_TX_ARB_STATS_EN
      for (int p = 0; p < PORTS; p++) begin
         chk($sformatf("t6_frame_cnt%0d", p), 32'(frame_cnt[p*16 +: 16]), (p == 1) ? 32'd3 : 32'd0);
         chk($sformatf("t6_abort_cnt%0d", p), 32'(abort_cnt[p*16 +: 16]), (p == 3) ? 32'd1 : 32'd0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
